// File: rtl/fifo_flag_ctrl_if.sv
// Request/enable handshake plus pointer, occupancy and status bundle for fifo_flag_ctrl.
// master = producer/consumer side, slave = the flag controller.
interface fifo_flag_ctrl_if #(
  parameter int ADDR_WIDTH = 9
);
  logic                  wr_req;
  logic                  rd_req;
  logic                  wr_en;
  logic                  rd_en;
  logic [ADDR_WIDTH:0]   wr_ptr;
  logic [ADDR_WIDTH:0]   rd_ptr;
  logic [ADDR_WIDTH:0]   level;
  logic                  full;
  logic                  empty;
  logic                  almost_full;
  logic                  almost_empty;
  logic                  overflow;
  logic                  underflow;

  modport master (
    output wr_req, rd_req,
    input  wr_en, rd_en, wr_ptr, rd_ptr, level,
    input  full, empty, almost_full, almost_empty, overflow, underflow
  );

  modport slave (
    input  wr_req, rd_req,
    output wr_en, rd_en, wr_ptr, rd_ptr, level,
    output full, empty, almost_full, almost_empty, overflow, underflow
  );
endinterface

// File: rtl/fifo_flag_ctrl.sv
// FIFO pointer/flag controller: combinational enables, flags registered from next pointers (0 extra latency).
// Requests are dropped when full/empty; define FIFO_ERR_FLAGS_EN to build sticky overflow/underflow flags.
module fifo_flag_ctrl #(
  parameter int ADDR_WIDTH = 9,
  parameter int AF_LEVEL   = (2 ** ADDR_WIDTH) - 4,
  parameter int AE_LEVEL   = 4
) (
  input  logic            clk,
  input  logic            rst,
  fifo_flag_ctrl_if.slave bus
);
  localparam int PW = ADDR_WIDTH + 1;
  localparam logic [ADDR_WIDTH:0] DEPTH_V = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0] AF_V    = PW'(AF_LEVEL);
  localparam logic [ADDR_WIDTH:0] AE_V    = PW'(AE_LEVEL);

  typedef enum logic [1:0] {
    ST_EMPTY   = 2'd0,
    ST_PARTIAL = 2'd1,
    ST_FULL    = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_WIDTH:0] wr_ptr_q, rd_ptr_q, level_q;
  logic [ADDR_WIDTH:0] wr_ptr_d, rd_ptr_d, level_d;
  logic                full_q, empty_q, af_q, ae_q;
  logic                wr_en, rd_en;
  logic                full_d, empty_d;

  assign wr_en = bus.wr_req & ~full_q  & ~rst;
  assign rd_en = bus.rd_req & ~empty_q & ~rst;

  assign wr_ptr_d = wr_ptr_q + {{ADDR_WIDTH{1'b0}}, wr_en};
  assign rd_ptr_d = rd_ptr_q + {{ADDR_WIDTH{1'b0}}, rd_en};
  // Modular subtraction keeps occupancy correct across pointer wrap.
  assign level_d  = wr_ptr_d - rd_ptr_d;
  assign empty_d  = (wr_ptr_d == rd_ptr_d);
  assign full_d   = ((wr_ptr_d ^ rd_ptr_d) == DEPTH_V);

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_EMPTY: begin
        if (wr_en && !rd_en) state_d = ST_PARTIAL;
      end
      ST_PARTIAL: begin
        if (level_d == DEPTH_V)   state_d = ST_FULL;
        else if (level_d == '0)   state_d = ST_EMPTY;
      end
      ST_FULL: begin
        if (rd_en) state_d = ST_PARTIAL;
      end
      default: state_d = ST_EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_EMPTY;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      af_q     <= 1'b0;
      ae_q     <= 1'b1;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
      af_q     <= (level_d >= AF_V);
      ae_q     <= (level_d <= AE_V);
    end
  end

`ifdef FIFO_ERR_FLAGS_EN
  logic overflow_q, underflow_q;

  // Sticky: only reset clears them.
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      overflow_q  <= overflow_q  | (bus.wr_req & full_q);
      underflow_q <= underflow_q | (bus.rd_req & empty_q);
    end
  end

  assign bus.overflow  = overflow_q;
  assign bus.underflow = underflow_q;
`else
  assign bus.overflow  = 1'b0;
  assign bus.underflow = 1'b0;
`endif

  assign bus.wr_en        = wr_en;
  assign bus.rd_en        = rd_en;
  assign bus.wr_ptr       = wr_ptr_q;
  assign bus.rd_ptr       = rd_ptr_q;
  assign bus.level        = level_q;
  assign bus.full         = full_q;
  assign bus.empty        = empty_q;
  assign bus.almost_full  = af_q;
  assign bus.almost_empty = ae_q;
endmodule

// File: doc/fifo_flag_ctrl.md
FIFO_FLAG_CTRL -- requirements
Module: fifo_flag_ctrl

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 9, the FIFO address width; DEPTH = 2**ADDR_WIDTH.
REQ-002 SHALL have parameter AF_LEVEL, default DEPTH-4, the almost-full threshold in entries.
REQ-003 SHALL have parameter AE_LEVEL, default 4, the almost-empty threshold in entries.
REQ-004 SHALL use one clock and a synchronous, active-high reset.
REQ-005 clk  input  1  clock; all state changes on its rising edge.
REQ-006 rst  input  1  synchronous, active-high reset.
REQ-007 wr_req  input  1  write request from the producer.
REQ-008 rd_req  input  1  read request from the consumer.
REQ-009 wr_en  output  1  qualified write enable to the memory and the write-pointer counter.
REQ-010 rd_en  output  1  qualified read enable to the memory and the read-pointer counter.
REQ-011 wr_ptr  output  ADDR_WIDTH+1  write pointer; MSB is the wrap bit.
REQ-012 rd_ptr  output  ADDR_WIDTH+1  read pointer; MSB is the wrap bit.
REQ-013 level  output  ADDR_WIDTH+1  occupancy, 0..DEPTH.
REQ-014 full, empty, almost_full, almost_empty  output  1 each  registered status flags.
REQ-015 overflow, underflow  output  1 each  sticky error flags (see Configuration).

Function
REQ-016 wr_en SHALL be combinational and equal to wr_req AND NOT full.
REQ-017 rd_en SHALL be combinational and equal to rd_req AND NOT empty.
REQ-018 wr_ptr SHALL increment by 1, modulo 2**(ADDR_WIDTH+1), on each cycle in which wr_en=1; it SHALL hold otherwise.
REQ-019 rd_ptr SHALL increment by 1, modulo 2**(ADDR_WIDTH+1), on each cycle in which rd_en=1; it SHALL hold otherwise.
REQ-020 Occupancy state machine with states EMPTY, PARTIAL and FULL; all flags SHALL be registered and derived from the next-state pointers, so they are valid in the same cycle as the updated pointers (zero extra latency).
REQ-021 EMPTY SHALL move to PARTIAL on wr_en with no rd_en; DEPTH=1 is not supported.
REQ-022 PARTIAL SHALL move to FULL when next level equals DEPTH.
REQ-023 PARTIAL SHALL move to EMPTY when next level equals 0.
REQ-024 FULL SHALL move to PARTIAL on rd_en.
REQ-025 empty SHALL be asserted when next wr_ptr equals next rd_ptr.
REQ-026 full SHALL be asserted when the next pointers differ only in the MSB.
REQ-027 level SHALL equal wr_ptr minus rd_ptr, computed in ADDR_WIDTH+1 bits; wrap-around of the pointers SHALL NOT corrupt it.
REQ-028 almost_full SHALL equal (level >= AF_LEVEL).
REQ-029 almost_empty SHALL equal (level <= AE_LEVEL).
REQ-030 Simultaneous wr_req and rd_req in PARTIAL SHALL assert both enables; pointers SHALL both advance, and level and flags SHALL be unchanged.
REQ-031 Simultaneous requests when full SHALL perform the read only; level SHALL become DEPTH-1.
REQ-032 Simultaneous requests when empty SHALL perform the write only; level SHALL become 1.

Reset
REQ-033 While rst=1 at a clk edge, the block SHALL load: wr_ptr=0, rd_ptr=0, level=0, state EMPTY, empty=1, almost_empty=1, full=0, almost_full=0, overflow=0, underflow=0.
REQ-034 wr_en and rd_en SHALL be forced to 0 while rst=1.
REQ-035 Reset asserted mid-operation SHALL override any concurrent request in that cycle.
REQ-036 The first request SHALL be honoured in the cycle after rst deasserts.

Configuration
REQ-037 With macro FIFO_ERR_FLAGS_EN defined, overflow SHALL set on any cycle with wr_req=1 and full=1, and clear only on reset.
REQ-038 With macro FIFO_ERR_FLAGS_EN defined, underflow SHALL set on any cycle with rd_req=1 and empty=1, and clear only on reset.
REQ-039 With FIFO_ERR_FLAGS_EN undefined, overflow and underflow SHALL be constant 0 and no error registers SHALL be built.

Verification (ADDR_WIDTH=2, DEPTH=4, AF_LEVEL=3, AE_LEVEL=1)
REQ-040 Reset, then 4 consecutive writes -> level 1,2,3,4; almost_empty drops after the 2nd write; almost_full rises after the 3rd write; full=1 after the 4th write.
REQ-041 From full, wr_req=1 for 1 cycle -> wr_en=0, wr_ptr unchanged, level=4; overflow=1 if FIFO_ERR_FLAGS_EN is defined, else 0.
REQ-042 From full, wr_req=1 and rd_req=1 together -> rd_en=1, wr_en=0, level=3, full=0.
REQ-043 Run 10 write-then-read pairs so the pointers wrap past 7 -> level stays within 0..1, empty=1 after each read, no false full.
REQ-044 From empty, rd_req=1 -> rd_en=0, underflow=1 if FIFO_ERR_FLAGS_EN is defined.
REQ-045 Then wr_req=1 and rd_req=1 together -> level=1, empty=0.
REQ-046 At level=2, rst=1 for 1 cycle together with wr_req=1 -> all outputs at reset values; the write is not performed.
